apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master_if.sv | 51 +++++
 rtl/apb_req_master.sv | 143 ++++++++++++++
 tb/tb_apb_req_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// Request/response and APB bus bundle for apb_req_master.
// master = the bridge's view, slave = requester + APB target view.
interface apb_req_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write,
    input  req_wdata, req_wstrb, req_prot,
    input  rsp_ready,
    input  out_pready, out_prdata, out_pslverr,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output out_paddr, out_psel, out_penable,
    output out_pprot, out_pwrite,
    output out_pwdata, out_pstrb
  );

  modport slave (
    output req_valid, req_addr, req_write,
    output req_wdata, req_wstrb, req_prot,
    output rsp_ready,
    output out_pready, out_prdata, out_pslverr,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  out_paddr, out_psel, out_penable,
    input  out_pprot, out_pwrite,
    input  out_pwdata, out_pstrb
  );
endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding request/response to APB master bridge.
// Optional ACCESS-phase timeout abort enabled by APB_TIMEOUT_EN.
module apb_req_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  apb_req_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [2:0]  pprot_q, pprot_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_hit;

`ifdef APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LIMIT =
                      CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts ACCESS cycles already spent without pready
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      state_q == SETUP:
        cnt_d = '0;
      state_q == ACCESS && !bus.out_pready:
        cnt_d = cnt_q + 1'b1;
      default:
        cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tmo_hit = (cnt_q == LIMIT);
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_write ?
                     bus.req_wdata : 32'h0;
          pstrb_d  = bus.req_write ?
                     bus.req_wstrb : 4'h0;
          pprot_d  = bus.req_prot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout in the same cycle
        if (bus.out_pready) begin
          rdata_d = pwrite_q ?
                    32'h0 : bus.out_prdata;
          err_d   = bus.out_pslverr;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= 32'h0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'h0;
      pstrb_q  <= 4'h0;
      pprot_q  <= 3'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.out_psel    = (state_q == SETUP) ||
                           (state_q == ACCESS);
  assign bus.out_penable = (state_q == ACCESS);
  assign bus.out_paddr   = paddr_q;
  assign bus.out_pwrite  = pwrite_q;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = pstrb_q;
  assign bus.out_pprot   = pprot_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: vector table,
// random transactions vs. a transaction-level model, corner cases.
module tb_apb_req_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_req_master_if bus();

  apb_req_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          rsp_wait;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Number of ACCESS cycles the transfer occupies
  function automatic int acc_cycles(input int waits);
`ifdef APB_TIMEOUT_EN
    return (waits + 1 > TO) ? TO : waits + 1;
`else
    return waits + 1;
`endif
  endfunction

  function automatic logic timed_out(input int waits);
`ifdef APB_TIMEOUT_EN
    return (waits + 1 > TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (timed_out(v.waits)) begin
      r.exp_rdata = 32'h0;
      r.exp_err   = 1'b1;
    end else begin
      r.exp_rdata = v.write ? 32'h0 : v.prdata;
      r.exp_err   = v.slverr;
    end
    return r;
  endfunction

  task automatic chk_bus(input vec_t v);
    chk("paddr", bus.out_paddr, v.addr);
    chk("pwrite", bus.out_pwrite, v.write);
    chk("pwdata", bus.out_pwdata,
        v.write ? v.wdata : 32'h0);
    chk("pstrb", bus.out_pstrb,
        v.write ? v.wstrb : 4'h0);
    chk("pprot", bus.out_pprot, v.prot);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    n = acc_cycles(v.waits);
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    chk("idle_psel", bus.out_psel, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_write = v.write;
    bus.req_wdata = v.wdata;
    bus.req_wstrb = v.wstrb;
    bus.req_prot  = v.prot;
    bus.rsp_ready = 1'b0;
    bus.out_pready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    chk("setup_psel", bus.out_psel, 1);
    chk("setup_penable", bus.out_penable, 0);
    chk("setup_req_ready", bus.req_ready, 0);
    chk_bus(v);
    bus.out_pready  = $urandom_range(0, 1);
    bus.out_prdata  = $urandom;
    bus.out_pslverr = $urandom_range(0, 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("acc_psel", bus.out_psel, 1);
      chk("acc_penable", bus.out_penable, 1);
      chk("acc_rsp_valid", bus.rsp_valid, 0);
      chk_bus(v);
      bus.out_pready  = (i == v.waits);
      bus.out_prdata  = (i == v.waits) ?
                        v.prdata : $urandom;
      bus.out_pslverr = (i == v.waits) ?
                        v.slverr : 1'($urandom);
    end
    for (int j = 0; j <= v.rsp_wait; j++) begin
      @(negedge clk);
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_psel", bus.out_psel, 0);
      chk("rsp_penable", bus.out_penable, 0);
      chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
      chk("rsp_err", bus.rsp_err, v.exp_err);
      chk("rsp_req_ready", bus.req_ready, 0);
      bus.out_pready  = $urandom_range(0, 1);
      bus.out_prdata  = $urandom;
      bus.out_pslverr = $urandom_range(0, 1);
      bus.rsp_ready   = (j == v.rsp_wait);
    end
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.out_pready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  vec_t tbl [5];

  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000,
               0, 32'h1234_5678, 1'b0, 0,
               32'h1234_5678, 1'b0};
    tbl[1] = '{1'b1, 32'hA000_0010, 32'hCAFE_F00D,
               4'b0101, 3'b010, 3, 32'hDEAD_BEEF, 1'b0, 1,
               32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'b001,
               0, 32'h5555_AAAA, 1'b1, 4,
               32'h5555_AAAA, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_0304, 32'h0BAD_F00D,
               4'b1111, 3'b111, 1, 32'h1111_2222, 1'b1, 0,
               32'h0, 1'b1};
    tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h7777_7777,
               4'b1010, 3'b101, 2, 32'h8765_4321, 1'b0, 2,
               32'h8765_4321, 1'b0};

    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 32'h0;
    bus.req_write   = 1'b0;
    bus.req_wdata   = 32'h0;
    bus.req_wstrb   = 4'h0;
    bus.req_prot    = 3'h0;
    bus.rsp_ready   = 1'b0;
    bus.out_pready  = 1'b0;
    bus.out_prdata  = 32'h0;
    bus.out_pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", bus.out_psel, 0);
    chk("rst_penable", bus.out_penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_paddr", bus.out_paddr, 0);
    chk("rst_pwdata", bus.out_pwdata, 0);
    chk("rst_pstrb", bus.out_pstrb, 0);
    chk("rst_pprot", bus.out_pprot, 0);
    chk("rst_pwrite", bus.out_pwrite, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_txn(tbl[k]);

    for (int k = 0; k < 30; k++) begin
      v.write    = 1'($urandom);
      v.addr     = $urandom;
      v.wdata    = $urandom;
      v.wstrb    = 4'($urandom);
      v.prot     = 3'($urandom);
      v.waits    = $urandom_range(0, 4);
`ifdef APB_TIMEOUT_EN
      if ($urandom_range(0, 3) == 0)
        v.waits = $urandom_range(TO - 2, TO + 4);
`endif
      v.prdata   = $urandom;
      v.slverr   = 1'($urandom);
      v.rsp_wait = $urandom_range(0, 3);
      run_txn(model(v));
    end

`ifdef APB_TIMEOUT_EN
    v = tbl[0];
    v.waits = TO + 20;
    run_txn(model(v));
    v.waits = TO - 1;
    run_txn(model(v));
`endif

    // Reset during ACCESS cycle 2 of a write
    @(negedge clk);
    chk("rx_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4000_0008;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h1357_9BDF;
    bus.req_wstrb = 4'b0011;
    bus.req_prot  = 3'b110;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.out_pready = 1'b0;
    @(negedge clk);
    chk("rx_acc1_penable", bus.out_penable, 1);
    @(negedge clk);
    chk("rx_acc2_penable", bus.out_penable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_pready = 1'b1;
    chk("rx_psel", bus.out_psel, 0);
    chk("rx_penable", bus.out_penable, 0);
    chk("rx_rsp_valid", bus.rsp_valid, 0);
    chk("rx_req_ready", bus.req_ready, 1);
    chk("rx_paddr", bus.out_paddr, 0);
    chk("rx_pwdata", bus.out_pwdata, 0);
    chk("rx_pstrb", bus.out_pstrb, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rx_quiet_rsp", bus.rsp_valid, 0);
      chk("rx_quiet_psel", bus.out_psel, 0);
      chk("rx_quiet_rdy", bus.req_ready, 1);
    end
    bus.out_pready = 1'b0;
    run_txn(tbl[4]);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

endmodule
